mem_addr_station: RTL
=====================

MEM_ADDR_STATION -- requirements
Module: mem_addr_station

Interface
REQ-001 Parameter: STATION_DEPTH, default 8, number of buffered memory-op entries (power of two, 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: dispatch_valid  input  1  dispatch presents one load/store this cycle.
REQ-005 Port: ps1  input  6  physical register holding the base address.
REQ-006 Port: ps1_ready  input  1  ps1 value is already available in the regfile.
REQ-007 Port: ps1_v  input  32  regfile value of ps1; meaningful only when ps1_ready=1.
REQ-008 Port: imm  input  32  sign-extended offset.
REQ-009 Port: mem_idx_in  input  6  memory-queue slot assigned by dispatch.
REQ-010 Port: cdb_valid  input  1  common data bus broadcast valid.
REQ-011 Port: cdb_pd  input  6  broadcast physical destination.
REQ-012 Port: cdb_data  input  32  broadcast value.
REQ-013 Port: flush  input  1  synchronous kill of all entries.
REQ-014 Port: addr  output  32  computed effective address, to the memory queue.
REQ-015 Port: addr_valid  output  1  addr and mem_idx_out valid this cycle (one-cycle pulse per op).
REQ-016 Port: mem_idx_out  output  6  memory-queue slot the address belongs to.
REQ-017 Port: full  output  1  no free entry; dispatch must stall.

Function
REQ-018 Each entry SHALL hold: valid, base_ready, ps1, base value (32), imm (32), mem_idx (6).
REQ-019 On dispatch_valid with full=0, the lowest-index invalid entry SHALL be written and marked valid at the next edge; dispatch_valid with full=1 SHALL be ignored.
REQ-020 Dispatched base_ready SHALL be 1 if ps1_ready=1 (value ps1_v), or if cdb_valid=1 and cdb_pd==ps1 the same cycle (value cdb_data); otherwise 0.
REQ-021 Every valid entry with base_ready=0 whose ps1 equals cdb_pd while cdb_valid=1 SHALL capture cdb_data and set base_ready at the next edge.
REQ-022 cdb_pd==0 broadcasts SHALL be ignored for wakeup; ps1==0 is always dispatched with ps1_ready=1.
REQ-023 Each cycle the lowest-index entry with valid=1 and base_ready=1 (registered state only) SHALL be selected; at most one issue per cycle.
REQ-024 Selected entry: addr SHALL be base+imm modulo 2^32, registered, with addr_valid=1 and mem_idx_out=entry mem_idx on the next cycle; the entry SHALL be invalidated at that same edge.
REQ-025 Latency: ready dispatch in cycle N -> addr_valid in cycle N+2 at earliest; CDB wakeup in cycle N -> addr_valid in N+2 at earliest.
REQ-026 addr_valid SHALL be 0 in any cycle following a cycle with no selectable entry; addr and mem_idx_out SHALL hold their last values when addr_valid=0.
REQ-027 full SHALL be derived from registered valid bits only (all STATION_DEPTH valid); a slot freed by issue is reusable from the following cycle.
REQ-028 Dispatch, CDB wakeup and issue in the same cycle SHALL all take effect; a freed slot is never written the same cycle it is freed.
REQ-029 flush=1 SHALL clear all valid bits and force addr_valid=0 at the next edge, overriding dispatch and issue that cycle.

Reset
REQ-030 While rst=1, all entry valid and base_ready bits, addr_valid, full, addr and mem_idx_out SHALL be 0, asynchronously.
REQ-031 rst asserted mid-operation SHALL discard all buffered entries; no addr_valid pulse occurs until a new dispatch after rst deasserts.

Verification
REQ-032 Ready dispatch: ps1_ready=1, ps1_v=0x1000, imm=0xFFFFFFFC, mem_idx_in=5 in cycle 0 -> addr_valid=1, addr=0x00000FFC, mem_idx_out=5 in cycle 2 only.
REQ-033 Wakeup: dispatch ps1=12 not ready, imm=8; cycle 3 cdb_valid, cdb_pd=12, cdb_data=0x2000 -> addr=0x2008 with addr_valid in cycle 5; cdb_pd=0 broadcast earlier causes no wakeup.
REQ-034 Fill/stall: 8 non-ready dispatches -> full=1; 9th dispatch ignored; one wakeup and issue -> full=0 one cycle after issue, subsequent dispatch accepted.
REQ-035 Arbitration: entries 2 and 6 become ready the same cycle -> entry 2 addr issued first, entry 6 one cycle later; wrap case base=0xFFFFFFF0, imm=0x20 -> addr=0x00000010.
REQ-036 Flush/reset: flush with 3 ready entries -> no addr_valid afterwards, full=0; rst pulse mid-stream -> all outputs 0 immediately, no stale issue after release.

Source files
------------

// File: rtl/mem_addr_station.sv
// Address-generation station for loads/stores: buffers ops until their base
// register is ready, then issues base+imm to the memory queue one op per cycle.
module mem_addr_station #(
  parameter int STATION_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dispatch_valid,
  input  logic [5:0]  ps1,
  input  logic        ps1_ready,
  input  logic [31:0] ps1_v,
  input  logic [31:0] imm,
  input  logic [5:0]  mem_idx_in,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_pd,
  input  logic [31:0] cdb_data,
  input  logic        flush,
  output logic [31:0] addr,
  output logic        addr_valid,
  output logic [5:0]  mem_idx_out,
  output logic        full
);
  localparam int IW = (STATION_DEPTH > 1) ? $clog2(STATION_DEPTH) : 1;

  logic [STATION_DEPTH-1:0] valid;
  logic [STATION_DEPTH-1:0] base_ready;
  logic [5:0]               ps1_q  [STATION_DEPTH];
  logic [31:0]              base_q [STATION_DEPTH];
  logic [31:0]              imm_q  [STATION_DEPTH];
  logic [5:0]               midx_q [STATION_DEPTH];

  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic [IW-1:0] free_idx;
  logic          wake;
  logic          disp_ready;
  logic [31:0]   disp_base;
  logic          disp_take;

  // Physical register 0 is hardwired, so its broadcasts never wake anything.
  assign wake       = cdb_valid && (cdb_pd != 6'd0);
  assign disp_ready = ps1_ready || (wake && (cdb_pd == ps1));
  assign disp_base  = ps1_ready ? ps1_v : cdb_data;
  assign full       = &valid;
  assign disp_take  = dispatch_valid && !full;

  // Selection and allocation look only at registered state, so a slot freed
  // by issue this cycle cannot be reallocated until the next one.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    free_idx  = '0;
    for (int i = STATION_DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && base_ready[i]) begin
        sel_idx   = i[IW-1:0];
        sel_found = 1'b1;
      end
      if (!valid[i]) free_idx = i[IW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= '0;
      base_ready  <= '0;
      addr        <= '0;
      addr_valid  <= 1'b0;
      mem_idx_out <= '0;
      for (int i = 0; i < STATION_DEPTH; i++) begin
        ps1_q[i]  <= '0;
        base_q[i] <= '0;
        imm_q[i]  <= '0;
        midx_q[i] <= '0;
      end
    end else if (flush) begin
      valid      <= '0;
      addr_valid <= 1'b0;
    end else begin
      for (int i = 0; i < STATION_DEPTH; i++) begin
        if (valid[i] && !base_ready[i] && wake && (ps1_q[i] == cdb_pd)) begin
          base_ready[i] <= 1'b1;
          base_q[i]     <= cdb_data;
        end
      end
      addr_valid <= sel_found;
      if (sel_found) begin
        addr           <= base_q[sel_idx] + imm_q[sel_idx];
        mem_idx_out    <= midx_q[sel_idx];
        valid[sel_idx] <= 1'b0;
      end
      if (disp_take) begin
        valid[free_idx]      <= 1'b1;
        base_ready[free_idx] <= disp_ready;
        ps1_q[free_idx]      <= ps1;
        base_q[free_idx]     <= disp_base;
        imm_q[free_idx]      <= imm;
        midx_q[free_idx]     <= mem_idx_in;
      end
    end
  end
endmodule
